// File: rtl/wb_master_bridge.sv
// wb_master_bridge
// Turns one valid/ready request from a core into one Wishbone pipelined
// transaction and returns a single-cycle response. A watchdog limits how long
// cyc can stay high, so an unmapped or hung slave cannot hold the bus.
//
// state | meaning
// IDLE  | no transaction in flight; req_ready is high
// REQ   | cyc and stb high, request held stable until the slave drops stall
// WAIT  | request taken by the slave; cyc held, waiting for ack or err
module wb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  input  logic [DATA_WIDTH/8-1:0]   req_sel,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [DATA_WIDTH/8-1:0]   o_wb_sel,
  output logic [ADDR_WIDTH-1:0]     o_wb_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_err
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  // 16 bits covers the whole legal TIMEOUT range.
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_cnt;
  logic                    r_cyc;
  logic                    r_stb;
  logic                    r_we;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  logic                    w_done;
  logic                    w_accept;
  logic                    w_complete;
  logic [15:0]             w_cnt_inc;
  logic                    w_timeout;

  // Completion is only legal once the slave has taken the request: in WAIT,
  // or on the very edge where stall is low in REQ. err has priority over ack.
  assign w_done     = i_wb_ack | i_wb_err;
  assign w_accept   = (r_state == S_REQ) & ~i_wb_stall;
  assign w_complete = ((r_state == S_WAIT) | w_accept) & w_done;
  assign w_cnt_inc  = r_cnt + 16'd1;
  // A completion on the same edge as the watchdog expiry wins.
  assign w_timeout  = (r_state != S_IDLE) & ~w_complete & (w_cnt_inc == TIMEOUT_CNT);

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_sel  = r_sel;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_wdata;

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Late acks/errs from a timed-out slave land here and are dropped.
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_data;
            r_sel   <= req_sel;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_complete) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= i_wb_err;
            if (r_we)
              r_rsp_data <= '0;
            else if (i_wb_err)
              r_rsp_data <= ERR_DATA;
            else
              r_rsp_data <= i_wb_data;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= r_we ? '0 : ERR_DATA;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_accept) begin
              r_stb   <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone pipelined initiator. Converts a single-outstanding valid/ready request from a core (CPU or CNN control sequencer) into one Wishbone classic-pipelined transaction.
- Drives the slave-side port of the system interconnect (RAM, UART, GPIO, CNN regions).
- Returns read data or error status on a one-cycle response strobe.
- Bounds every transaction with a watchdog timeout so that an unmapped or hung slave cannot lock the bus.

Parameters:
ADDR_WIDTH, 32, width of req_addr and o_wb_addr
DATA_WIDTH, 32, width of all data buses; o_wb_sel width is DATA_WIDTH/8
TIMEOUT, 255, cycles with cyc high and no ack/err before abort; legal range 2..65535
ERR_DATA, 32'hDEAD_BEEF, value returned on rsp_data for timeout/err on a read

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  1  core request present
req_ready  out  1  bridge can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_data  in  DATA_WIDTH  write data
req_sel  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  valid with rsp_valid; 1 = slave err or timeout
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  Wishbone write enable
o_wb_sel  out  DATA_WIDTH/8  byte select
o_wb_addr  out  ADDR_WIDTH  address
o_wb_data  out  DATA_WIDTH  write data
i_wb_data  in  DATA_WIDTH  read data from slave
i_wb_ack  in  1  slave acknowledge
i_wb_stall  in  1  slave stall
i_wb_err  in  1  slave error

Behaviour:
- Reset (rst=0, asynchronous):
  - Go to IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, rsp_valid and rsp_err = 0.
  - o_wb_sel, o_wb_addr, o_wb_data and rsp_data = 0.
  - Timeout counter = 0.
  - Reset asserted mid-transaction drops cyc/stb immediately. No response is issued.
- All outputs are registered. req_ready = (state==IDLE), combinational from state.
- IDLE:
  - On req_valid at an edge: latch we/addr/data/sel onto the o_wb_* registers, and assert cyc=1, stb=1. Go to REQ.
  - i_wb_ack and i_wb_err are ignored in IDLE.
- REQ (cyc=1, stb=1):
  - stb and all request fields stay stable while i_wb_stall=1.
  - An edge with i_wb_stall=0 accepts the request: stb=0 next cycle, go to WAIT.
  - If i_wb_ack or i_wb_err is also sampled at that accepting edge, complete directly (see completion).
- WAIT (cyc=1, stb=0): on an edge with i_wb_ack or i_wb_err, complete.
- Completion:
  - Next cycle: cyc=0, state=IDLE, rsp_valid=1 for exactly one cycle.
  - rsp_err=i_wb_err.
  - rsp_data: i_wb_data for a read ack; 0 for a write; ERR_DATA on err for a read.
  - If ack and err arrive together, err wins.
- Timeout:
  - Counter clears when cyc rises and increments every cycle that cyc=1.
  - When the counter reaches TIMEOUT with no ack/err: drop cyc and stb, pulse rsp_valid with rsp_err=1, rsp_data=ERR_DATA for a read or 0 for a write. Go to IDLE.
  - An ack arriving on the same edge the counter hits TIMEOUT counts as a normal completion.
- Back-to-back: req_ready=1 in the rsp_valid cycle, so a new request may be accepted then. cyc then deasserts for at least that one cycle between transactions.
- Latency: with stall=0 and a registered slave ack, req accepted at edge E0 → stb high in cycle 1 → ack sampled at E2 → rsp_valid in cycle 3.
- Acks received after a timeout (state IDLE) are discarded.

Test Plan:
1. Read, no stall: req addr=0x0000_0010, slave acks one cycle after stb with data 0x1234_5678 → stb high exactly 1 cycle; rsp_valid one cycle after the ack edge; rsp_data=0x1234_5678; rsp_err=0.
2. Write with stall: req_we=1, addr=0x2000_0004, data=0xA5A5_0F0F, sel=4'b0011, stall held 3 cycles → stb held 4 cycles with addr/data/sel constant; after ack, rsp_valid=1, rsp_data=0, rsp_err=0.
3. Timeout: TIMEOUT=8, read with slave never acking → cyc drops after 8 cycles of cyc; rsp_valid=1, rsp_err=1, rsp_data=0xDEAD_BEEF. A late ack 2 cycles after that produces no rsp_valid.
4. Error, same-cycle accept: stall=0 with ack=1 and err=1 at the accepting edge → single rsp_valid, rsp_err=1, rsp_data=0xDEAD_BEEF, cyc=0 the next cycle.
5. Back-to-back: two reads issued with req_valid held high → second request accepted in the first rsp_valid cycle; cyc low for exactly one cycle between the two transactions; both rsp_data values correct.
6. Reset mid-transaction: rst=0 asynchronously while in WAIT → cyc/stb go to 0 without waiting for an edge. After release: req_ready=1, no rsp_valid, and a fresh read completes normally.
